tlb_maint_ctrl: RTL and testbench

Sequencer for TLB management instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) targeting a RAM-based TLB entry array. The array has one synchronous read port with 1-cycle latency and one write port. Sits between the M2 pipeline stage / CSR block and the TLB array, and stalls the pipeline via a valid/ready handshake. SRCH and INV walk entries sequentially with a pipelined read/compare. WR/FILL/INV completion requests a pipeline refetch.

---
 rtl/tlb_maint_ctrl_if.sv | 29 ++
 rtl/tlb_maint_ctrl.sv | 94 +++++++++
 tb/tb_tlb_maint_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_maint_ctrl_if.sv
// tlb_maint_ctrl_if: op request/completion bundle plus the TLB entry-array read/write port
interface tlb_maint_ctrl_if #(
  parameter int INDEX_LEN = 5
);
  logic                 op_valid_i, op_ready_o;
  logic [2:0]           op_i;
  logic [4:0]           inv_op_i;
  logic [9:0]           inv_asid_i, csr_asid_i;
  logic [18:0]          inv_vppn_i, csr_vppn_i;
  logic [INDEX_LEN-1:0] csr_index_i, ent_raddr_o, ent_waddr_o, srch_index_o;
  logic                 ent_re_o, ent_we_o, ent_clr_o;
  logic                 ent_e_i, ent_g_i;
  logic [9:0]           ent_asid_i;
  logic [18:0]          ent_vppn_i;
  logic [5:0]           ent_ps_i;
  logic                 done_o, err_o, flush_o, rd_valid_o, srch_found_o;
  modport slave (
    input  op_valid_i, op_i, inv_op_i, inv_asid_i, inv_vppn_i, csr_vppn_i, csr_asid_i, csr_index_i,
    input  ent_e_i, ent_g_i, ent_asid_i, ent_vppn_i, ent_ps_i,
    output op_ready_o, ent_raddr_o, ent_re_o, ent_waddr_o, ent_we_o, ent_clr_o,
    output done_o, err_o, flush_o, rd_valid_o, srch_found_o, srch_index_o
  );
  modport master (
    output op_valid_i, op_i, inv_op_i, inv_asid_i, inv_vppn_i, csr_vppn_i, csr_asid_i, csr_index_i,
    output ent_e_i, ent_g_i, ent_asid_i, ent_vppn_i, ent_ps_i,
    input  op_ready_o, ent_raddr_o, ent_re_o, ent_waddr_o, ent_we_o, ent_clr_o,
    input  done_o, err_o, flush_o, rd_valid_o, srch_found_o, srch_index_o
  );
endinterface

// File: rtl/tlb_maint_ctrl.sv
// tlb_maint_ctrl: sequences TLBSRCH/RD/WR/FILL/INVTLB over a 1-cycle-latency TLB entry RAM
module tlb_maint_ctrl #(
  parameter  int TLB_ENTRY_NUM = 32,
  localparam int INDEX_LEN     = $clog2(TLB_ENTRY_NUM)
) (
  input logic             clk,
  input logic             rst_n,
  tlb_maint_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WALK, RD_ISSUE, WRITE, DONE} state_t;
  localparam logic [2:0] OP_SRCH = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2, OP_FILL = 3'd3, OP_INV = 3'd4;
  localparam logic [INDEX_LEN-1:0] LAST = INDEX_LEN'(TLB_ENTRY_NUM - 1);
  state_t               r_state, w_next;
  logic [2:0]           r_op;
  logic [4:0]           r_inv_op;
  logic [9:0]           r_asid;
  logic [18:0]          r_vppn;
  logic                 r_err, r_cmp_v, r_found;
  logic [INDEX_LEN-1:0] r_index, r_fill, r_cmp_idx, r_srch_idx;
  logic [INDEX_LEN:0]   r_cnt;
  logic                 w_illegal, w_issue, w_cmp, w_vppn_eq, w_asid_eq, w_srch_hit, w_inv_hit, w_walk_end;
  assign w_illegal  = bus.op_i > OP_INV || (bus.op_i == OP_INV && bus.inv_op_i > 5'd6);
  assign w_issue    = r_state == WALK && !r_cnt[INDEX_LEN];
  assign w_cmp      = r_state == WALK && r_cmp_v;
  assign w_vppn_eq  = bus.ent_ps_i == 6'd21 ? bus.ent_vppn_i[18:9] == r_vppn[18:9] : bus.ent_vppn_i == r_vppn;
  assign w_asid_eq  = bus.ent_asid_i == r_asid;
  assign w_srch_hit = w_cmp && r_op == OP_SRCH && bus.ent_e_i && (bus.ent_g_i || w_asid_eq) && w_vppn_eq;
  // the walk ends on the first SRCH hit, otherwise once the last index has been compared
  assign w_walk_end = w_srch_hit || (w_cmp && r_cmp_idx == LAST);
  always_comb begin
    w_inv_hit = 1'b0;
    case (r_inv_op)
      5'd0, 5'd1: w_inv_hit = 1'b1;
      5'd2:       w_inv_hit = bus.ent_g_i;
      5'd3:       w_inv_hit = !bus.ent_g_i;
      5'd4:       w_inv_hit = !bus.ent_g_i && w_asid_eq;
      5'd5:       w_inv_hit = !bus.ent_g_i && w_asid_eq && w_vppn_eq;
      5'd6:       w_inv_hit = (bus.ent_g_i || w_asid_eq) && w_vppn_eq;
      default:    w_inv_hit = 1'b0;
    endcase
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:            if (bus.op_valid_i) w_next = w_illegal ? DONE : (bus.op_i inside {OP_SRCH, OP_INV}) ? WALK : bus.op_i == OP_RD ? RD_ISSUE : WRITE;
      WALK:            if (w_walk_end) w_next = DONE;
      RD_ISSUE, WRITE: w_next = DONE;
      default:         w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (r_state == IDLE && bus.op_valid_i) begin
      r_op     <= bus.op_i;
      r_inv_op <= bus.inv_op_i;
      r_index  <= bus.csr_index_i;
      r_err    <= w_illegal;
      r_asid   <= bus.op_i == OP_INV ? bus.inv_asid_i : bus.csr_asid_i;
      r_vppn   <= bus.op_i == OP_INV ? bus.inv_vppn_i : bus.csr_vppn_i;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_cmp_v    <= 1'b0;
      r_cmp_idx  <= '0;
      r_fill     <= '0;
      r_found    <= 1'b0;
      r_srch_idx <= '0;
    end else begin
      r_cmp_v   <= w_issue;
      r_cmp_idx <= r_cnt[INDEX_LEN-1:0];
      r_cnt     <= r_state == IDLE ? '0 : w_issue ? r_cnt + 1'b1 : r_cnt;
      if (r_state == WRITE && r_op == OP_FILL) r_fill <= r_fill + 1'b1;
      if (r_op == OP_SRCH && w_walk_end) begin
        r_found <= w_srch_hit;
        if (w_srch_hit) r_srch_idx <= r_cmp_idx;
      end
    end
  end
  // compare index trails read address by one, so a clear never hits the entry being read
  assign bus.op_ready_o   = r_state == IDLE;
  assign bus.ent_re_o     = w_issue || r_state == RD_ISSUE;
  assign bus.ent_raddr_o  = r_state == WALK ? r_cnt[INDEX_LEN-1:0] : r_index;
  assign bus.ent_we_o     = r_state == WRITE;
  assign bus.ent_clr_o    = w_cmp && r_op == OP_INV && w_inv_hit;
  assign bus.ent_waddr_o  = r_state == WALK ? r_cmp_idx : r_op == OP_FILL ? r_fill : r_index;
  assign bus.done_o       = r_state == DONE;
  assign bus.err_o        = r_state == DONE && r_err;
  assign bus.flush_o      = r_state == DONE && !r_err && (r_op inside {OP_WR, OP_FILL, OP_INV});
  assign bus.rd_valid_o   = r_state == DONE && !r_err && r_op == OP_RD;
  assign bus.srch_found_o = r_found;
  assign bus.srch_index_o = r_srch_idx;
endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// tb_tlb_maint_ctrl: directed and randomized checks of tlb_maint_ctrl against a TLB array/op model
module tb_tlb_maint_ctrl;
  localparam int N = 32, IL = 5;
  typedef struct packed {logic e; logic g; logic [9:0] asid; logic [18:0] vppn; logic [5:0] ps;} ent_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  tlb_maint_ctrl_if #(.INDEX_LEN(IL)) bus();
  tlb_maint_ctrl #(.TLB_ENTRY_NUM(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  ent_t mem [N];
  ent_t exp_mem [N];
  ent_t rdat, wr_ent, bd_ent;
  logic bd_we = 1'b0;
  logic [IL-1:0] bd_idx = '0;
  int n_chk = 0, n_pass = 0, n_hz = 0;
  int fill_m = 0;
  logic found_m = 1'b0;
  logic [IL-1:0] sidx_m = '0;
  int o_done, o_re1, o_nwe, o_nre;
  logic o_err, o_flush, o_rdv, o_found;
  logic [IL-1:0] o_sidx, o_ra, o_wa;
  logic [N-1:0] o_clr;
  ent_t o_rdat;
  always @(posedge clk) begin
    if (bus.ent_re_o) rdat <= mem[bus.ent_raddr_o];
    if (bus.ent_we_o) mem[bus.ent_waddr_o] <= wr_ent;
    if (bus.ent_clr_o) mem[bus.ent_waddr_o].e <= 1'b0;
    if (bd_we) mem[bd_idx] <= bd_ent;
  end
  assign bus.ent_e_i    = rdat.e;
  assign bus.ent_g_i    = rdat.g;
  assign bus.ent_asid_i = rdat.asid;
  assign bus.ent_vppn_i = rdat.vppn;
  assign bus.ent_ps_i   = rdat.ps;
  always @(negedge clk) begin
    if (rst_n && bus.ent_we_o && bus.ent_clr_o) n_hz++;
    if (rst_n && bus.ent_re_o && (bus.ent_we_o || bus.ent_clr_o) && bus.ent_raddr_o == bus.ent_waddr_o) n_hz++;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic ent_t mk(input logic e, input logic g, input logic [9:0] a, input logic [18:0] v, input logic [5:0] ps);
    return {e, g, a, v, ps};
  endfunction
  function automatic logic veq(input ent_t x, input logic [18:0] v);
    return x.ps == 6'd21 ? x.vppn[18:9] == v[18:9] : x.vppn == v;
  endfunction
  function automatic logic srch_hit(input ent_t x, input logic [9:0] a, input logic [18:0] v);
    return x.e && (x.g || x.asid == a) && veq(x, v);
  endfunction
  function automatic logic inv_hit(input ent_t x, input logic [4:0] op, input logic [9:0] a, input logic [18:0] v);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2: return x.g;
      5'd3: return !x.g;
      5'd4: return !x.g && x.asid == a;
      5'd5: return !x.g && x.asid == a && veq(x, v);
      5'd6: return (x.g || x.asid == a) && veq(x, v);
      default: return 1'b0;
    endcase
  endfunction
  function automatic ent_t rnd_ent();
    ent_t x;
    x.e = 1'($urandom);
    x.g = $urandom_range(0, 3) == 0;
    x.asid = $urandom_range(0, 1) ? 10'd3 : 10'($urandom);
    case ($urandom_range(0, 2))
      0: x.vppn = 19'h12345;
      1: x.vppn = 19'h12345 ^ 19'($urandom_range(1, 511));
      default: x.vppn = 19'($urandom);
    endcase
    x.ps = $urandom_range(0, 1) ? 6'd21 : 6'd12;
    return x;
  endfunction
  task automatic bd(input int i, input ent_t x);
    bd_we = 1'b1; bd_idx = IL'(i); bd_ent = x;
    @(negedge clk);
    bd_we = 1'b0;
    exp_mem[i] = x;
  endtask
  task automatic clear_all();
    for (int i = 0; i < N; i++) bd(i, mk(1'b0, 1'b0, 10'($urandom), 19'($urandom), 6'd12));
  endtask
  task automatic scramble();
    bus.op_i = 3'($urandom); bus.inv_op_i = 5'($urandom);
    bus.inv_asid_i = 10'($urandom); bus.inv_vppn_i = 19'($urandom);
    bus.csr_asid_i = 10'($urandom); bus.csr_vppn_i = 19'($urandom); bus.csr_index_i = IL'($urandom);
  endtask
  task automatic run_op(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] a, input logic [18:0] v, input logic [IL-1:0] ci);
    chk("ready_before", bus.op_ready_o, 1);
    scramble();
    bus.op_valid_i = 1'b1; bus.op_i = op; bus.inv_op_i = iop; bus.csr_index_i = ci;
    if (op == 3'd4) begin bus.inv_asid_i = a; bus.inv_vppn_i = v; end
    else begin bus.csr_asid_i = a; bus.csr_vppn_i = v; end
    @(negedge clk);
    bus.op_valid_i = 1'b0;
    scramble();
    o_done = -1; o_re1 = -1; o_nwe = 0; o_nre = 0; o_clr = '0;
    for (int c = 1; c <= 100 && o_done < 0; c++) begin
      if (bus.ent_re_o) begin
        if (o_re1 < 0) begin o_re1 = c; o_ra = bus.ent_raddr_o; end
        o_nre++;
      end
      if (bus.ent_we_o) begin o_nwe++; o_wa = bus.ent_waddr_o; end
      if (bus.ent_clr_o) o_clr[bus.ent_waddr_o] = 1'b1;
      if (bus.done_o) begin
        o_done = c; o_err = bus.err_o; o_flush = bus.flush_o; o_rdv = bus.rd_valid_o;
        o_found = bus.srch_found_o; o_sidx = bus.srch_index_o; o_rdat = rdat;
      end else @(negedge clk);
    end
    if (o_done < 0) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_single", bus.done_o, 0);
    chk("ready_after", bus.op_ready_o, 1);
  endtask
  task automatic do_op(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] a, input logic [18:0] v, input logic [IL-1:0] ci);
    logic bad;
    int e_done, k;
    logic [N-1:0] e_clr;
    bad = op > 3'd4 || (op == 3'd4 && iop > 5'd6);
    e_clr = '0; k = -1; e_done = 2;
    if (bad) e_done = 1;
    else if (op == 3'd0) begin
      for (int i = N - 1; i >= 0; i--) if (srch_hit(exp_mem[i], a, v)) k = i;
      e_done = k < 0 ? N + 2 : k + 3;
    end else if (op == 3'd4) begin
      for (int i = 0; i < N; i++) e_clr[i] = inv_hit(exp_mem[i], iop, a, v);
      e_done = N + 2;
    end
    run_op(op, iop, a, v, ci);
    chk("done_latency", o_done, e_done);
    chk("err", o_err, bad);
    if (!bad) begin
      chk("flush", o_flush, op >= 3'd2);
      chk("rd_valid", o_rdv, op == 3'd1);
      chk("clear_set", o_clr, e_clr);
      chk("write_count", o_nwe, op == 3'd2 || op == 3'd3);
      if (op == 3'd2 || op == 3'd3) chk("write_addr", o_wa, op == 3'd2 ? ci : IL'(fill_m));
      else chk("first_read_cycle", o_re1, 1);
      if (op == 3'd1) begin
        chk("read_addr", o_ra, ci);
        chk("read_data", o_rdat, exp_mem[ci]);
      end
      if (op == 3'd0) begin
        found_m = k >= 0;
        if (k >= 0) sidx_m = IL'(k);
      end
      if (op == 3'd2) exp_mem[ci] = wr_ent;
      if (op == 3'd3) begin exp_mem[fill_m] = wr_ent; fill_m = (fill_m + 1) % N; end
      for (int i = 0; i < N; i++) if (e_clr[i]) exp_mem[i].e = 1'b0;
    end else chk("no_access", o_nre + o_nwe + $countones(o_clr), 0);
    chk("srch_found", o_found, found_m);
    chk("srch_index", o_sidx, sidx_m);
  endtask
  initial begin
    int mis, dn;
    logic [2:0] op;
    bus.op_valid_i = 1'b0; scramble(); wr_ent = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.op_ready_o, 1);
    chk("rst_found", bus.srch_found_o, 0);
    chk("rst_index", bus.srch_index_o, 0);
    chk("rst_done", bus.done_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N + 1; i++) begin
      wr_ent = rnd_ent();
      do_op(3'd3, 5'd0, 10'd0, 19'd0, IL'(0));
    end
    chk("fill_wrap_addr", o_wa, 0);
    clear_all();
    bd(5, mk(1'b1, 1'b0, 10'd3, 19'h12345, 6'd12));
    do_op(3'd0, 5'd0, 10'd3, 19'h12345, IL'(0));
    chk("t_hit5_latency", o_done, 8);
    chk("t_hit5_index", o_sidx, 5);
    do_op(3'd0, 5'd0, 10'd4, 19'h12345, IL'(0));
    chk("t_miss_latency", o_done, N + 2);
    chk("t_miss_index_held", o_sidx, 5);
    bd(5, mk(1'b0, 1'b0, 10'd3, 19'h12345, 6'd12));
    bd(2, mk(1'b1, 1'b1, 10'd7, 19'h12345, 6'd12));
    bd(9, mk(1'b1, 1'b0, 10'd3, 19'h12345 ^ 19'h0AB, 6'd21));
    do_op(3'd0, 5'd0, 10'd3, 19'h12345, IL'(0));
    chk("t_two_hits_index", o_sidx, 2);
    bd(2, mk(1'b0, 1'b1, 10'd7, 19'h12345, 6'd12));
    do_op(3'd0, 5'd0, 10'd3, 19'h12345, IL'(0));
    chk("t_ps21_index", o_sidx, 9);
    clear_all();
    bd(5, mk(1'b1, 1'b0, 10'd3, 19'h12345, 6'd12));
    bd(7, mk(1'b1, 1'b1, 10'd5, 19'h12345, 6'd12));
    do_op(3'd4, 5'd5, 10'd3, 19'h12345, IL'(0));
    chk("t_inv5_clears", o_clr, 32'h20);
    do_op(3'd4, 5'd2, 10'd3, 19'h12345, IL'(0));
    chk("t_inv2_clears", o_clr, 32'h80);
    do_op(3'd4, 5'd0, 10'd0, 19'd0, IL'(0));
    chk("t_inv0_count", $countones(o_clr), N);
    do_op(3'd4, 5'd7, 10'd3, 19'h12345, IL'(0));
    chk("t_badinv_err", o_err, 1);
    do_op(3'd6, 5'd0, 10'd3, 19'h12345, IL'(0));
    chk("t_badop_latency", o_done, 1);
    for (int i = 0; i < N; i++) bd(i, rnd_ent());
    do_op(3'd1, 5'd0, 10'd0, 19'd0, IL'(7));
    chk("t_rd7_issue", o_re1, 1);
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 7) == 0 ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      wr_ent = rnd_ent();
      do_op(op, 5'($urandom_range(0, 7)), $urandom_range(0, 1) ? 10'd3 : 10'($urandom_range(0, 7)),
            $urandom_range(0, 2) != 0 ? 19'h12345 : 19'($urandom), IL'($urandom));
    end
    clear_all();
    scramble();
    bus.op_valid_i = 1'b1; bus.op_i = 3'd0;
    @(negedge clk);
    bus.op_valid_i = 1'b0;
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done_o) dn++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    if (bus.done_o) dn++;
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.done_o) dn++;
    chk("abort_no_done", dn, 0);
    chk("abort_ready", bus.op_ready_o, 1);
    fill_m = 0; found_m = 1'b0; sidx_m = '0;
    wr_ent = rnd_ent();
    do_op(3'd3, 5'd0, 10'd0, 19'd0, IL'(0));
    chk("abort_fill_restart", o_wa, 0);
    chk("hazards", n_hz, 0);
    mis = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_mem[i]) mis++;
    chk("array_state", mis, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
